bmult_acc: RTL

- Downstream accumulation stage for the Bmult8x8 family of multipliers.
- Consumes the 16-bit product stream P, one term per beat, through a valid/ready handshake.
- Sums a burst of products (a dot product terminated by p_last) into a wider accumulator.
- Presents the sum, term count and overflow flag on an output handshake that holds until the result is taken.

---
 rtl/bmult_acc_if.sv | 27 ++
 rtl/bmult_acc.sv | 118 +++++++++++
 2 files changed

// File: rtl/bmult_acc_if.sv
// Product-in / sum-out handshake bundle for the bmult_acc accumulation stage.
// master drives products and takes results; slave is the accumulator.
interface bmult_acc_if #(
  parameter int unsigned P_W   = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 9
);
  logic             p_valid;
  logic             p_ready;
  logic [P_W-1:0]   p_data;
  logic             p_last;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] sum_data;
  logic [CNT_W-1:0] sum_count;
  logic             sum_ovf;

  modport master (
    output p_valid, p_data, p_last, sum_ready,
    input  p_ready, sum_valid, sum_data, sum_count, sum_ovf
  );

  modport slave (
    input  p_valid, p_data, p_last, sum_ready,
    output p_ready, sum_valid, sum_data, sum_count, sum_ovf
  );
endinterface

// File: rtl/bmult_acc.sv
// Sums a p_last-terminated burst of unsigned products into an ACC_W accumulator and
// holds the sum, term count and sticky carry flag until the consumer takes them.
module bmult_acc #(
  parameter int unsigned P_W       = 16,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned MAX_TERMS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  bmult_acc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_TERMS) + 1;
  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_TERMS);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             sum_valid_q;
  logic [ACC_W-1:0] sum_data_q;
  logic [CNT_W-1:0] sum_count_q;
  logic             sum_ovf_q;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic [CNT_W-1:0] count_inc;
  logic             force_end;
  logic             p_ready;
  logic             p_fire;
  logic             sum_fire;

  always_comb begin
    p_ext            = '0;
    p_ext[P_W-1:0]   = bus.p_data;
    acc_sum          = {1'b0, acc_q} + {1'b0, p_ext};
    carry            = acc_sum[ACC_W];
    count_inc        = count_q + CNT_W'(1);
    force_end        = (count_inc == MaxCount);
  end

  // Not registered: ready must drop with reset and reappear only after HOLD is left.
  assign p_ready  = rst_n && (state_q != StHold);
  assign p_fire   = bus.p_valid && p_ready;
  assign sum_fire = sum_valid_q && bus.sum_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
    end else if (clr) begin
      // Result registers keep stale data; only the valid is dropped.
      state_q     <= StIdle;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (p_fire) begin
            acc_q   <= p_ext;
            count_q <= CNT_W'(1);
            ovf_q   <= 1'b0;
            if (bus.p_last || (MAX_TERMS == 1)) begin
              state_q     <= StHold;
              sum_valid_q <= 1'b1;
              sum_data_q  <= p_ext;
              sum_count_q <= CNT_W'(1);
              sum_ovf_q   <= 1'b0;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (p_fire) begin
            acc_q   <= acc_sum[ACC_W-1:0];
            count_q <= count_inc;
            ovf_q   <= ovf_q | carry;
            if (bus.p_last || force_end) begin
              state_q     <= StHold;
              sum_valid_q <= 1'b1;
              sum_data_q  <= acc_sum[ACC_W-1:0];
              sum_count_q <= count_inc;
              sum_ovf_q   <= ovf_q | carry;
            end
          end
        end
        StHold: begin
          if (sum_fire) begin
            state_q     <= StIdle;
            sum_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.p_ready   = p_ready;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_data  = sum_data_q;
  assign bus.sum_count = sum_count_q;
  assign bus.sum_ovf   = sum_ovf_q;
endmodule
